// File: rtl/kuuga_mem_pkg.sv
// Shared definitions for the BRAM port-A initiator: latency default, FSM encoding,
// response tag layout and the byte-lane merge used by read-modify-write.
package kuuga_mem_pkg;

  localparam int BRAM_READ_LATENCY = 2;
  localparam int WORD_BYTES        = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic is_read;
    logic is_rmw;
  } resp_tag_t;

  function automatic logic [8*WORD_BYTES-1:0] merge_bytes(
    input logic [8*WORD_BYTES-1:0] old_w,
    input logic [8*WORD_BYTES-1:0] new_w,
    input logic [WORD_BYTES-1:0]   be
  );
    logic [8*WORD_BYTES-1:0] m;
    m = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/bram_obi_initiator_if.sv
// Core-side data port of the BRAM initiator.
// Handshake: a request transfers in a cycle where req_i && gnt_o; every transfer gets exactly
// one rvalid_o pulse later, in order, and rvalid_o is never back-pressured.
interface bram_obi_initiator_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/bram_resp_pipe.sv
// Fixed-depth tag shift register that tracks outstanding BRAM accesses; advances every cycle.
module bram_resp_pipe #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_obi_initiator.sv
// OBI-style core port to word-write-only BRAM port A; partial stores become read-modify-write.
module bram_obi_initiator
  import kuuga_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = BRAM_READ_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  bram_obi_initiator_if.slave     bus,
  output logic                    bram_clk_a,
  output logic                    bram_rst_a,
  output logic                    bram_en_a,
  output logic [WORD_BYTES-1:0]   bram_we_a,
  output logic [ADDR_WIDTH-1:0]   bram_addr_a,
  output logic [DATA_WIDTH-1:0]   bram_wrdata_a,
  input  logic [DATA_WIDTH-1:0]   bram_rddata_a,
  output state_t                  dbg_state_o
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   rmw_addr_q, rmw_addr_d;
  logic [WORD_BYTES-1:0]   rmw_be_q, rmw_be_d;
  logic [DATA_WIDTH-1:0]   rmw_wdata_q, rmw_wdata_d;
  resp_tag_t               tag_in, tag_out;
  logic                    accept, is_partial, rmw_commit;
  logic                    unused_addr;

  assign unused_addr = ^{bus.addr_i[31:ADDR_WIDTH], bus.addr_i[1:0]};
  assign bram_clk_a  = clk;
  assign bram_rst_a  = reset;
  assign dbg_state_o = state_q;

  assign is_partial = (bus.be_i != '0) && (bus.be_i != '1);
  assign accept     = bus.req_i && bus.gnt_o;
  // The RMW write lands exactly when its own read data emerges from the memory.
  assign rmw_commit = (state_q == ST_RMW) && tag_out.valid && tag_out.is_rmw && !reset;

  bram_resp_pipe #(
    .W     ($bits(resp_tag_t)),
    .DEPTH (READ_LATENCY)
  ) u_resp_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_be_d    = rmw_be_q;
    rmw_wdata_d = rmw_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.we_i && is_partial) begin
          state_d     = ST_RMW;
          rmw_addr_d  = bus.addr_i[ADDR_WIDTH-1:2];
          rmw_be_d    = bus.be_i;
          rmw_wdata_d = bus.wdata_i;
        end
      end
      ST_RMW: begin
        if (rmw_commit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o     = (state_q == ST_IDLE) && bus.req_i && !reset;
    bram_en_a     = 1'b0;
    bram_we_a     = '0;
    bram_addr_a   = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
    bram_wrdata_a = bus.wdata_i;
    tag_in        = '0;
    if (rmw_commit) begin
      bram_en_a     = 1'b1;
      bram_we_a     = '1;
      bram_addr_a   = {rmw_addr_q, 2'b00};
      bram_wrdata_a = merge_bytes(bram_rddata_a, rmw_wdata_q, rmw_be_q);
    end else if (accept) begin
      tag_in.valid = 1'b1;
      if (!bus.we_i) begin
        bram_en_a      = 1'b1;
        tag_in.is_read = 1'b1;
      end else if (bus.be_i == '1) begin
        bram_en_a = 1'b1;
        bram_we_a = '1;
      end else if (is_partial) begin
        bram_en_a     = 1'b1;
        tag_in.is_rmw = 1'b1;
      end
    end
    bus.rvalid_o = tag_out.valid && !reset;
    bus.rdata_o  = (bus.rvalid_o && tag_out.is_read) ? bram_rddata_a : '0;
  end

endmodule
